pipe_ctrl: RTL and testbench

- Central pipeline sequencing controller for the 5-stage core (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Merges stall requests from fetch, ID and multi-cycle EX operations into one per-stage stall vector.
- Runs the EX multi-cycle occupancy counter.
- Sequences branch/exception flushes, deferring a flush while EX is busy.

---
 rtl/pipe_ctrl.sv | 138 +++++++++++++
 tb/tb_pipe_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges fetch/ID/EX stall requests, runs the EX
// multi-cycle counter and sequences (possibly deferred) flushes. PIPE_CTRL_PERF_EN adds perf counters.
module pipe_ctrl #(
  parameter int MC_W    = 4,
  parameter int STALL_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_stall_req,
  input  logic               id_stall_req,
  input  logic               ex_mc_start,
  input  logic [MC_W-1:0]    ex_mc_len,
  input  logic               flush_req,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic               ex_mc_last,
  output logic               mc_busy
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]        perf_stall_cyc,
  output logic [15:0]        perf_flush_cnt
`endif
);

  localparam logic [STALL_W-1:0] MASK_IF = STALL_W'(6'b000011);
  localparam logic [STALL_W-1:0] MASK_ID = STALL_W'(6'b000111);
  localparam logic [STALL_W-1:0] MASK_EX = STALL_W'(6'b001111);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MC_BUSY = 2'd1,
    S_FLUSH   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [MC_W-1:0] cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic            start_long;

  // Lengths 0 and 1 both complete in the start cycle, so only N>1 occupies EX.
  assign start_long = ex_mc_start && (ex_mc_len > MC_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_long) begin
          state_d = S_MC_BUSY;
          cnt_d   = ex_mc_len - MC_W'(2);
          pend_d  = flush_req;
        end else if (flush_req) begin
          state_d = S_FLUSH;
        end
      end
      S_MC_BUSY: begin
        if (flush_req) pend_d = 1'b1;
        // A flush arriving in the final busy cycle is folded into the pending one.
        if (cnt_q == '0) begin
          state_d = (pend_q || flush_req) ? S_FLUSH : S_IDLE;
          pend_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - MC_W'(1);
        end
      end
      S_FLUSH: begin
        state_d = S_IDLE;
        pend_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    stall      = '0;
    flush      = 1'b0;
    ex_mc_last = 1'b0;
    mc_busy    = 1'b0;
    if (!rst) begin
      if (if_stall_req) stall = stall | MASK_IF;
      if (id_stall_req) stall = stall | MASK_ID;
      unique case (state_q)
        S_IDLE: begin
          if (start_long) stall = stall | MASK_EX;
          ex_mc_last = ex_mc_start && !start_long;
        end
        S_MC_BUSY: begin
          stall      = stall | MASK_EX;
          mc_busy    = 1'b1;
          ex_mc_last = (cnt_q == '0);
        end
        S_FLUSH: flush = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cyc_q;
  logic [15:0] perf_flush_cnt_q;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cyc_q <= '0;
      perf_flush_cnt_q <= '0;
    end else begin
      if (stall[0] && (perf_stall_cyc_q != '1)) perf_stall_cyc_q <= perf_stall_cyc_q + 32'd1;
      if (flush && (perf_flush_cnt_q != '1))    perf_flush_cnt_q <= perf_flush_cnt_q + 16'd1;
    end
  end

  assign perf_stall_cyc = perf_stall_cyc_q;
  assign perf_flush_cnt = perf_flush_cnt_q;
`endif

  // Starting a new multi-cycle op while EX is still occupied is a caller bug.
  ap_no_start_in_busy: assert property (@(posedge clk) disable iff (rst)
    !(state_q == S_MC_BUSY && ex_mc_start));

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a cycle-level reference model pushes expected outputs,
// a negedge monitor pops and compares. Perf counters are checked when PIPE_CTRL_PERF_EN is set.
module tb_pipe_ctrl;
  localparam int MC_W    = 4;
  localparam int STALL_W = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst = 1'b1;
  logic               if_stall_req = 1'b0, id_stall_req = 1'b0;
  logic               ex_mc_start = 1'b0, flush_req = 1'b0;
  logic [MC_W-1:0]    ex_mc_len = '0;
  logic [STALL_W-1:0] stall;
  logic               flush, ex_mc_last, mc_busy;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]        perf_stall_cyc;
  logic [15:0]        perf_flush_cnt;
`endif

  pipe_ctrl #(.MC_W(MC_W), .STALL_W(STALL_W)) dut (
    .clk(clk), .rst(rst),
    .if_stall_req(if_stall_req), .id_stall_req(id_stall_req),
    .ex_mc_start(ex_mc_start), .ex_mc_len(ex_mc_len), .flush_req(flush_req),
    .stall(stall), .flush(flush), .ex_mc_last(ex_mc_last), .mc_busy(mc_busy)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  typedef struct packed {
    logic [5:0] stall;
    logic       flush;
    logic       last;
    logic       busy;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;

  // Reference model: remaining EX-occupied cycles, pending flush, flush due next cycle.
  int busy_left = 0;
  bit pend      = 1'b0;
  bit flush_now = 1'b0;

  task automatic cyc(input bit r, input bit ir, input bit dr, input bit s,
                     input logic [3:0] l, input bit f);
    exp_t e;
    int   n;
    @(posedge clk);
    #1;
    rst = r; if_stall_req = ir; id_stall_req = dr;
    ex_mc_start = s; ex_mc_len = l; flush_req = f;
    e = '0;
    if (r) begin
      busy_left = 0; pend = 1'b0; flush_now = 1'b0;
    end else begin
      e.stall = (ir ? 6'b000011 : 6'b000000) | (dr ? 6'b000111 : 6'b000000);
      if (flush_now) begin
        e.flush   = 1'b1;
        flush_now = 1'b0;
      end else if (busy_left > 0) begin
        e.stall   = e.stall | 6'b001111;
        e.busy    = 1'b1;
        e.last    = (busy_left == 1);
        pend      = pend | f;
        busy_left = busy_left - 1;
        if (busy_left == 0) begin
          flush_now = pend;
          pend      = 1'b0;
        end
      end else if (s) begin
        n = (l < 2) ? 1 : int'(l);
        if (n > 1) begin
          e.stall   = e.stall | 6'b001111;
          busy_left = n - 1;
          pend      = f;
        end else begin
          e.last    = 1'b1;
          flush_now = f;
        end
      end else if (f) begin
        flush_now = 1'b1;
      end
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 4'd0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    cycle++;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({stall, flush, ex_mc_last, mc_busy} !== e) begin
        errors++;
        $display("FAIL outputs @%0d: got stall=%b flush=%b last=%b busy=%b, expected stall=%b flush=%b last=%b busy=%b",
                 cycle, stall, flush, ex_mc_last, mc_busy, e.stall, e.flush, e.last, e.busy);
      end
    end
  end

  initial begin
    bit s, ir, dr, f, r;
    // Reset, then quiet idle.
    cyc(1, 1, 1, 0, 4'd0, 1);
    cyc(1, 0, 0, 0, 4'd0, 0);
    idle(4);
    // Length-4 op followed by one idle-cycle flush (also the perf scenario).
    cyc(0, 0, 0, 1, 4'd4, 0);
    idle(3);
    cyc(0, 0, 0, 0, 4'd0, 1);
    idle(2);
`ifdef PIPE_CTRL_PERF_EN
    @(negedge clk);
    checks++;
    if (perf_stall_cyc !== 32'd4) begin
      errors++;
      $display("FAIL perf_stall_cyc: got %0d, expected 4", perf_stall_cyc);
    end
    checks++;
    if (perf_flush_cnt !== 16'd1) begin
      errors++;
      $display("FAIL perf_flush_cnt: got %0d, expected 1", perf_flush_cnt);
    end
`endif
    // Fetch wait plus ID hazard for two cycles.
    cyc(0, 1, 1, 0, 4'd0, 0);
    cyc(0, 1, 1, 0, 4'd0, 0);
    idle(1);
    // Length-4 op with a flush one cycle later: deferred to t+4.
    cyc(0, 0, 0, 1, 4'd4, 0);
    cyc(0, 0, 0, 0, 4'd0, 1);
    idle(5);
    // Length-8 op aborted by reset at t+2.
    cyc(0, 0, 0, 1, 4'd8, 0);
    idle(1);
    cyc(1, 0, 0, 0, 4'd0, 0);
    idle(10);
    // Degenerate lengths, start+flush collision, repeated flushes while pending.
    cyc(0, 0, 0, 1, 4'd0, 0);
    cyc(0, 0, 0, 1, 4'd1, 0);
    cyc(0, 0, 0, 1, 4'd1, 1);
    idle(2);
    cyc(0, 0, 0, 1, 4'd3, 1);
    cyc(0, 0, 1, 0, 4'd0, 1);
    cyc(0, 1, 0, 0, 4'd0, 1);
    idle(3);
    cyc(0, 0, 0, 1, 4'd15, 0);
    idle(13);
    cyc(0, 0, 0, 0, 4'd0, 1);
    idle(3);
    // Randomized traffic; starts only issued when EX is free and no flush is due.
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 59) == 0);
      ir = ($urandom_range(0, 3) == 0);
      dr = ($urandom_range(0, 4) == 0);
      f  = ($urandom_range(0, 6) == 0);
      s  = (busy_left == 0) && !flush_now && ($urandom_range(0, 2) == 0);
      cyc(r, ir, dr, s, 4'($urandom_range(0, 15)), f);
    end
    idle(2);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard-drain: got %0d entries left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
